// File: rtl/ddr_cmd_scheduler_pkg.sv
// Shared types and default timing for the DDR4 command scheduler.
package ddr_pkg;

  localparam int unsigned ROW_W      = 15;
  localparam int unsigned COL_W      = 10;
  localparam int unsigned NUM_BANKS  = 16;
  localparam int unsigned BANK_IDX_W = 4;

  localparam int unsigned T_RCD_DEF = 16;
  localparam int unsigned T_RP_DEF  = 16;
  localparam int unsigned T_RAS_DEF = 39;
  localparam int unsigned T_CCD_DEF = 4;
  localparam int unsigned T_RFC_DEF = 260;
  localparam int unsigned CL_DEF    = 16;
  localparam int unsigned CWL_DEF   = 12;

  // {cs_n, act_n, RAS_n/A16, CAS_n/A15, WE_n/A14}; ACT carries row[16:14] in the low bits
  typedef enum logic [4:0] {
    CMD_ACT = 5'b00000,
    CMD_REF = 5'b01001,
    CMD_PRE = 5'b01010,
    CMD_WR  = 5'b01100,
    CMD_RD  = 5'b01101,
    CMD_NOP = 5'b10111
  } cmd_e;

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_CAS,
    S_WAIT_CCD, S_PREA, S_WAIT_RPA, S_REF, S_WAIT_RFC
  } sched_state_e;

  typedef struct packed {
    logic             open;
    logic [ROW_W-1:0] row;
  } bank_entry_t;

  typedef struct packed {
    logic             wr;
    logic [1:0]       bg;
    logic [1:0]       ba;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } req_t;

  function automatic logic [BANK_IDX_W-1:0] bank_idx(input logic [1:0] bg, input logic [1:0] ba);
    return {bg, ba};
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b, input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ddr_cmd_scheduler_if.sv
// Request stream in, DDR4 command/address bus and data-phase strobes out.
interface ddr_cmd_scheduler_if;
  import ddr_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic             req_wr;
  logic [1:0]       req_bg;
  logic [1:0]       req_ba;
  logic [ROW_W-1:0] req_row;
  logic [COL_W-1:0] req_col;
  logic             ref_req;
  logic             ref_ack;
  logic [4:0]       cmd;
  logic [1:0]       cmd_bg;
  logic [1:0]       cmd_ba;
  logic [ROW_W-1:0] cmd_addr;
  logic             wr_rdy;
  logic             rd_rdy;

  modport master (
    output req_valid, req_wr, req_bg, req_ba, req_row, req_col, ref_req,
    input  req_ready, ref_ack, cmd, cmd_bg, cmd_ba, cmd_addr, wr_rdy, rd_rdy
  );

  modport slave (
    input  req_valid, req_wr, req_bg, req_ba, req_row, req_col, ref_req,
    output req_ready, ref_ack, cmd, cmd_bg, cmd_ba, cmd_addr, wr_rdy, rd_rdy
  );
endinterface

// File: rtl/ddr_cmd_scheduler_bank_table.sv
// Open-row table for 16 banks with per-bank tRAS down-counters.
module bank_table
  import ddr_pkg::*;
#(
  parameter int unsigned T_RAS = T_RAS_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [BANK_IDX_W-1:0] lk_idx_i,
  input  logic [ROW_W-1:0]      lk_row_i,
  output logic                  lk_hit_c_o,
  output logic                  lk_open_c_o,
  output logic                  lk_tras_ok_c_o,
  output logic                  all_tras_ok_c_o,
  output logic                  any_open_c_o,
  input  logic [BANK_IDX_W-1:0] upd_idx_i,
  input  logic [ROW_W-1:0]      upd_row_i,
  input  logic                  open_i,
  input  logic                  close_i,
  input  logic                  clear_all_i
);
  localparam int unsigned TRAS_W = $clog2(T_RAS) + 1;

  bank_entry_t       tbl_q  [NUM_BANKS];
  logic [TRAS_W-1:0] tras_q [NUM_BANKS];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NUM_BANKS); i++) begin
        tbl_q[i]  <= '0;
        tras_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_BANKS); i++) begin
        if (tras_q[i] != '0) tras_q[i] <= tras_q[i] - TRAS_W'(1);
        if (clear_all_i) begin
          tbl_q[i].open <= 1'b0;
        end else if (upd_idx_i == BANK_IDX_W'(i)) begin
          if (open_i) begin
            tbl_q[i].open <= 1'b1;
            tbl_q[i].row  <= upd_row_i;
            tras_q[i]     <= TRAS_W'(T_RAS - 1);
          end else if (close_i) begin
            tbl_q[i].open <= 1'b0;
          end
        end
      end
    end
  end

  // "ok" looks one cycle ahead so a PRE lands exactly when the counter expires
  always_comb begin
    all_tras_ok_c_o = 1'b1;
    any_open_c_o    = 1'b0;
    for (int i = 0; i < int'(NUM_BANKS); i++) begin
      if (tbl_q[i].open) begin
        any_open_c_o = 1'b1;
        if (tras_q[i] > TRAS_W'(1)) all_tras_ok_c_o = 1'b0;
      end
    end
  end

  assign lk_open_c_o    = tbl_q[lk_idx_i].open;
  assign lk_hit_c_o     = lk_open_c_o && (tbl_q[lk_idx_i].row == lk_row_i);
  assign lk_tras_ok_c_o = tras_q[lk_idx_i] <= TRAS_W'(1);

endmodule

// File: rtl/ddr_cmd_scheduler.sv
// DDR4 command sequencer: bank-state aware PRE/ACT/CAS issue, refresh, data-phase strobes.
module ddr_cmd_scheduler
  import ddr_pkg::*;
#(
  parameter int unsigned T_RCD = T_RCD_DEF,
  parameter int unsigned T_RP  = T_RP_DEF,
  parameter int unsigned T_RAS = T_RAS_DEF,
  parameter int unsigned T_CCD = T_CCD_DEF,
  parameter int unsigned T_RFC = T_RFC_DEF,
  parameter int unsigned CL    = CL_DEF,
  parameter int unsigned CWL   = CWL_DEF
) (
  input  logic            CK_t,
  input  logic            reset,
  ddr_cmd_scheduler_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(max3(T_RP, T_RCD, T_RFC)) + 1;
  localparam int unsigned CCD_W = $clog2(T_CCD) + 1;
  localparam logic [ROW_W-1:0] ADDR_A10 = ROW_W'(11'h400);

  sched_state_e     state_q, state_d;
  req_t             req_q, req_d, req_in;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CCD_W-1:0] tccd_q, tccd_d;
  logic             pre_done_q, pre_done_d;
  logic             ready_en_q;
  logic [4:0]       cmd_q, cmd_d;
  logic [1:0]       cmd_bg_q, cmd_bg_d, cmd_ba_q, cmd_ba_d;
  logic [ROW_W-1:0] cmd_addr_q, cmd_addr_d;
  logic             ref_ack_q, ref_ack_d;
  logic [CL-1:0]    rd_pipe_q;
  logic [CWL-1:0]   wr_pipe_q;
  logic [2:0]       act_hi;
  logic             cnt_zero, tccd_ok;
  logic             tbl_open, tbl_close, tbl_clear;
  logic [BANK_IDX_W-1:0] lk_idx;
  logic [ROW_W-1:0] lk_row;
  logic             lk_hit, lk_open, lk_tras_ok, all_tras_ok, any_open;

  assign req_in   = '{wr: bus.req_wr, bg: bus.req_bg, ba: bus.req_ba, row: bus.req_row, col: bus.req_col};
  assign lk_idx   = (state_q == S_IDLE) ? bank_idx(req_in.bg, req_in.ba) : bank_idx(req_q.bg, req_q.ba);
  assign lk_row   = (state_q == S_IDLE) ? req_in.row : req_q.row;
  assign cnt_zero = (cnt_q == '0);
  assign tccd_ok  = (tccd_q <= CCD_W'(1));
  assign act_hi   = 3'(17'(req_d.row) >> 14);

  bank_table #(.T_RAS(T_RAS)) u_bank_table (
    .clk_i          (CK_t),
    .rst_i          (reset),
    .lk_idx_i       (lk_idx),
    .lk_row_i       (lk_row),
    .lk_hit_c_o     (lk_hit),
    .lk_open_c_o    (lk_open),
    .lk_tras_ok_c_o (lk_tras_ok),
    .all_tras_ok_c_o(all_tras_ok),
    .any_open_c_o   (any_open),
    .upd_idx_i      (bank_idx(req_q.bg, req_q.ba)),
    .upd_row_i      (req_q.row),
    .open_i         (tbl_open),
    .close_i        (tbl_close),
    .clear_all_i    (tbl_clear)
  );

  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state; pre_done marks that the WAIT_RP/WAIT_RPA tRAS hold is over and PRE went out
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    pre_done_d = pre_done_q;
    case (state_q)
      S_IDLE: begin
        pre_done_d = 1'b0;
        if (bus.ref_req) begin
          if (!any_open)        state_d = S_REF;
          else if (all_tras_ok) state_d = S_PREA;
          else                  state_d = S_WAIT_RPA;
        end else if (bus.req_valid) begin
          req_d = req_in;
          if (lk_hit)       state_d = tccd_ok ? S_CAS : S_WAIT_CCD;
          else if (lk_open) state_d = lk_tras_ok ? S_PRE : S_WAIT_RP;
          else              state_d = S_ACT;
        end
      end
      S_PRE:      begin state_d = S_WAIT_RP;  pre_done_d = 1'b1; end
      S_WAIT_RP:  if (!pre_done_q) begin if (lk_tras_ok) state_d = S_PRE; end
                  else if (cnt_zero) state_d = S_ACT;
      S_ACT:      state_d = S_WAIT_RCD;
      S_WAIT_RCD: if (cnt_zero && tccd_ok) state_d = S_CAS;
      S_CAS:      state_d = S_IDLE;
      S_WAIT_CCD: if (tccd_ok) state_d = S_CAS;
      S_PREA:     begin state_d = S_WAIT_RPA; pre_done_d = 1'b1; end
      S_WAIT_RPA: if (!pre_done_q) begin if (all_tras_ok) state_d = S_PREA; end
                  else if (cnt_zero) state_d = S_REF;
      S_REF:      state_d = S_WAIT_RFC;
      S_WAIT_RFC: if (cnt_zero) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Outputs: bus command follows the state being entered; counters/table act on the command cycle
  always_comb begin
    cmd_d      = CMD_NOP;
    cmd_bg_d   = '0;
    cmd_ba_d   = '0;
    cmd_addr_d = '0;
    ref_ack_d  = 1'b0;
    cnt_d      = cnt_zero ? '0 : cnt_q - CNT_W'(1);
    tccd_d     = (tccd_q == '0) ? '0 : tccd_q - CCD_W'(1);
    tbl_open   = (state_q == S_ACT);
    tbl_close  = (state_q == S_PRE);
    tbl_clear  = (state_q == S_PREA) || (state_q == S_REF);
    case (state_d)
      S_ACT:  begin cmd_d = {2'b00, act_hi}; cmd_bg_d = req_d.bg; cmd_ba_d = req_d.ba; cmd_addr_d = req_d.row; end
      S_PRE:  begin cmd_d = CMD_PRE; cmd_bg_d = req_d.bg; cmd_ba_d = req_d.ba; end
      S_CAS:  begin
        cmd_d      = req_d.wr ? CMD_WR : CMD_RD;
        cmd_bg_d   = req_d.bg;
        cmd_ba_d   = req_d.ba;
        cmd_addr_d = ROW_W'(req_d.col);
      end
      S_PREA: begin cmd_d = CMD_PRE; cmd_addr_d = ADDR_A10; end
      S_REF:  begin cmd_d = CMD_REF; ref_ack_d = 1'b1; end
      default: ;
    endcase
    case (state_q)
      S_PRE, S_PREA: cnt_d  = CNT_W'(T_RP - 2);
      S_ACT:         cnt_d  = CNT_W'(T_RCD - 2);
      S_REF:         cnt_d  = CNT_W'(T_RFC - 2);
      S_CAS:         tccd_d = CCD_W'(T_CCD - 1);
      default: ;
    endcase
  end

  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      req_q      <= '0;
      cnt_q      <= '0;
      tccd_q     <= '0;
      pre_done_q <= 1'b0;
      ready_en_q <= 1'b0;
      cmd_q      <= CMD_NOP;
      cmd_bg_q   <= '0;
      cmd_ba_q   <= '0;
      cmd_addr_q <= '0;
      ref_ack_q  <= 1'b0;
      rd_pipe_q  <= '0;
      wr_pipe_q  <= '0;
    end else begin
      req_q      <= req_d;
      cnt_q      <= cnt_d;
      tccd_q     <= tccd_d;
      pre_done_q <= pre_done_d;
      ready_en_q <= (state_d == S_IDLE);
      cmd_q      <= cmd_d;
      cmd_bg_q   <= cmd_bg_d;
      cmd_ba_q   <= cmd_ba_d;
      cmd_addr_q <= cmd_addr_d;
      ref_ack_q  <= ref_ack_d;
      rd_pipe_q  <= {rd_pipe_q[CL-2:0],  (state_q == S_CAS) && !req_q.wr};
      wr_pipe_q  <= {wr_pipe_q[CWL-2:0], (state_q == S_CAS) &&  req_q.wr};
    end
  end

  assign bus.req_ready = ready_en_q && !bus.ref_req;
  assign bus.ref_ack   = ref_ack_q;
  assign bus.cmd       = cmd_q;
  assign bus.cmd_bg    = cmd_bg_q;
  assign bus.cmd_ba    = cmd_ba_q;
  assign bus.cmd_addr  = cmd_addr_q;
  assign bus.rd_rdy    = rd_pipe_q[CL-1];
  assign bus.wr_rdy    = wr_pipe_q[CWL-1];

endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// Directed bench for ddr_cmd_scheduler: logs every bus command/strobe with its cycle number.
module tb_ddr_cmd_scheduler;
  import ddr_pkg::*;

  logic CK_t  = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  ddr_cmd_scheduler_if bus ();

  ddr_cmd_scheduler dut (
    .CK_t (CK_t),
    .reset(reset),
    .bus  (bus)
  );

  always #5 CK_t = ~CK_t;
  always @(posedge CK_t) cyc <= cyc + 1;

  logic [4:0]  ev_cmd  [$];
  int          ev_cyc  [$];
  logic [14:0] ev_addr [$];
  logic [3:0]  ev_bank [$];
  int          rd_q    [$];
  int          wr_q    [$];
  int          ack_q   [$];

  always @(negedge CK_t) begin
    if (!reset) begin
      if (bus.cmd != 5'b10111) begin
        ev_cmd.push_back(bus.cmd);
        ev_cyc.push_back(cyc);
        ev_addr.push_back(bus.cmd_addr);
        ev_bank.push_back({bus.cmd_bg, bus.cmd_ba});
      end
      if (bus.rd_rdy)  rd_q.push_back(cyc);
      if (bus.wr_rdy)  wr_q.push_back(cyc);
      if (bus.ref_ack) ack_q.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_events();
    ev_cmd.delete(); ev_cyc.delete(); ev_addr.delete(); ev_bank.delete();
    rd_q.delete(); wr_q.delete(); ack_q.delete();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge CK_t);
    #1;
  endtask

  // Hold a request until accepted; acc is the cycle of the accepting edge
  task automatic send_req(input logic wr, input logic [1:0] bg, input logic [1:0] ba,
                          input logic [14:0] row, input logic [9:0] col, output int acc);
    bus.req_wr = wr; bus.req_bg = bg; bus.req_ba = ba;
    bus.req_row = row; bus.req_col = col;
    bus.req_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CK_t);
      if (bus.req_ready) begin
        acc = cyc;
        break;
      end
    end
    check_eq("req_accepted", 32'(acc >= 0), 32'd1);
    @(posedge CK_t);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic check_ev(input string tag, input int k, input logic [4:0] c, input int t,
                          input logic [14:0] addr, input logic [3:0] bank);
    check_eq($sformatf("%s_cmd", tag),  ev_cmd[k],  c);
    check_eq($sformatf("%s_cyc", tag),  ev_cyc[k],  t);
    check_eq($sformatf("%s_addr", tag), ev_addr[k], addr);
    check_eq($sformatf("%s_bank", tag), ev_bank[k], bank);
  endtask

  int a, a2, a3, c, d, e, f, h, x;
  bit seen;

  initial begin
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_bg = '0; bus.req_ba = '0;
    bus.req_row = '0; bus.req_col = '0; bus.ref_req = 1'b0;

    repeat (3) @(posedge CK_t);
    #1;
    check_eq("rst_cmd",      bus.cmd, 5'b10111);
    check_eq("rst_addr",     bus.cmd_addr, 0);
    check_eq("rst_bgba",     {bus.cmd_bg, bus.cmd_ba}, 0);
    check_eq("rst_ready",    bus.req_ready, 0);
    check_eq("rst_ref_ack",  bus.ref_ack, 0);
    check_eq("rst_rdy",      {bus.rd_rdy, bus.wr_rdy}, 0);
    reset = 1'b0;
    wait_cycles(2);

    // Empty read, row-hit write, then row conflict on the same bank
    clear_events();
    send_req(1'b0, 2'd1, 2'd2, 15'h100, 10'h020, a);
    send_req(1'b1, 2'd1, 2'd2, 15'h100, 10'h028, a2);
    send_req(1'b1, 2'd1, 2'd2, 15'h200, 10'h030, a3);
    wait_cycles(70);
    check_eq("a_acc2", a2, a + 18);
    check_eq("a_acc3", a3, a + 22);
    check_eq("a_nev", ev_cmd.size(), 6);
    check_ev("a_act1", 0, 5'b00000, a + 1,  15'h100, 4'd6);
    check_ev("a_rd",   1, 5'b01101, a + 17, 15'h020, 4'd6);
    check_ev("a_wr1",  2, 5'b01100, a + 21, 15'h028, 4'd6);
    check_ev("a_pre",  3, 5'b01010, a + 40, 15'h000, 4'd6);
    check_ev("a_act2", 4, 5'b00000, a + 56, 15'h200, 4'd6);
    check_ev("a_wr2",  5, 5'b01100, a + 72, 15'h030, 4'd6);
    check_eq("a_nrd", rd_q.size(), 1);
    check_eq("a_rdy_rd", rd_q[0], a + 33);
    check_eq("a_nwr", wr_q.size(), 2);
    check_eq("a_rdy_wr1", wr_q[0], a + 33);
    check_eq("a_rdy_wr2", wr_q[1], a + 84);

    // Refresh with two banks open, racing a request in the same cycle
    clear_events();
    send_req(1'b0, 2'd0, 2'd0, 15'h005, 10'h008, c);
    bus.ref_req = 1'b1;
    seen = 1'b0;
    fork
      begin
        for (int i = 0; i < 600; i++) begin
          @(negedge CK_t);
          if (bus.ref_ack) begin
            seen = 1'b1;
            break;
          end
        end
        bus.ref_req = 1'b0;
      end
      send_req(1'b0, 2'd3, 2'd3, 15'h007, 10'h001, d);
    join
    wait_cycles(40);
    check_eq("b_ack_seen", seen, 1);
    check_eq("b_acc", d, c + 316);
    check_eq("b_nev", ev_cmd.size(), 6);
    check_ev("b_act0", 0, 5'b00000, c + 1,   15'h005, 4'd0);
    check_ev("b_rd0",  1, 5'b01101, c + 17,  15'h008, 4'd0);
    check_ev("b_prea", 2, 5'b01010, c + 40,  15'h400, 4'd0);
    check_ev("b_ref",  3, 5'b01001, c + 56,  15'h000, 4'd0);
    check_ev("b_act1", 4, 5'b00000, c + 317, 15'h007, 4'd15);
    check_ev("b_rd1",  5, 5'b01101, c + 333, 15'h001, 4'd15);
    check_eq("b_nack", ack_q.size(), 1);
    check_eq("b_ack_cyc", ack_q[0], c + 56);
    check_eq("b_nrd", rd_q.size(), 2);
    check_eq("b_rdy0", rd_q[0], c + 33);
    check_eq("b_rdy1", rd_q[1], c + 349);

    // Reset between ACT and CAS
    clear_events();
    send_req(1'b0, 2'd2, 2'd1, 15'h033, 10'h004, e);
    check_eq("c_act_on_bus", bus.cmd, 5'b00000);
    reset = 1'b1;
    #1;
    check_eq("c_rst_cmd", bus.cmd, 5'b10111);
    check_eq("c_rst_bgba", {bus.cmd_bg, bus.cmd_ba}, 0);
    check_eq("c_rst_addr", bus.cmd_addr, 0);
    repeat (2) @(posedge CK_t);
    #1;
    reset = 1'b0;
    wait_cycles(2);
    clear_events();
    send_req(1'b0, 2'd2, 2'd1, 15'h033, 10'h004, f);
    wait_cycles(40);
    check_eq("c_nev", ev_cmd.size(), 2);
    check_ev("c_act", 0, 5'b00000, f + 1,  15'h033, 4'd9);
    check_ev("c_rd",  1, 5'b01101, f + 17, 15'h004, 4'd9);
    check_eq("c_nrd", rd_q.size(), 1);
    check_eq("c_rdy", rd_q[0], f + 33);

    // Four row-hit reads to four banks
    send_req(1'b0, 2'd3, 2'd0, 15'h001, 10'h000, x);
    send_req(1'b0, 2'd3, 2'd1, 15'h002, 10'h000, x);
    send_req(1'b0, 2'd3, 2'd2, 15'h003, 10'h000, x);
    wait_cycles(40);
    clear_events();
    send_req(1'b0, 2'd2, 2'd1, 15'h033, 10'h011, h);
    send_req(1'b0, 2'd3, 2'd0, 15'h001, 10'h012, x);
    send_req(1'b0, 2'd3, 2'd1, 15'h002, 10'h013, x);
    send_req(1'b0, 2'd3, 2'd2, 15'h003, 10'h014, x);
    wait_cycles(40);
    check_eq("d_nev", ev_cmd.size(), 4);
    check_eq("d_nrd", rd_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check_ev($sformatf("d_rd%0d", k), k, 5'b01101, h + 1 + 4 * k,
               15'(16'h0011 + 16'(k)), (k == 0) ? 4'd9 : 4'(11 + k));
      check_eq($sformatf("d_rdy%0d", k), rd_q[k], h + 17 + 4 * k);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
